// File: rtl/spi_frame_master_pkg.sv
// Shared constants, FSM encoding and elaboration helpers for the SPI frame master.
`timescale 1ns/1ps
package spi_frame_pkg;

  localparam int unsigned CMD_W      = 3;
  localparam int unsigned ADDR_W     = 9;
  localparam int unsigned DATA_W     = 8;
  localparam int unsigned FRAME_BITS = CMD_W + ADDR_W + DATA_W;

  localparam logic [CMD_W-1:0] CMD_READ  = 3'b110;
  localparam logic [CMD_W-1:0] CMD_WRITE = 3'b101;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEAD,
    ST_SHIFT,
    ST_TRAIL,
    ST_GAP
  } state_t;

  function automatic int unsigned max_of(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/spi_frame_master_bit_sync.sv
// Two-flop synchronizer bringing the slave's MISO into the sys_clk domain.
`timescale 1ns/1ps
module bit_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/spi_frame_master.sv
// Mode-0 SPI initiator: sends one FRAME_BITS command frame MSB-first on MOSI while
// capturing MISO, then returns the captured word with a single-cycle rx_valid.
`timescale 1ns/1ps
module spi_frame_master #(
  parameter int unsigned FRAME_BITS = spi_frame_pkg::FRAME_BITS,
  parameter int unsigned CLK_DIV    = 10,
  parameter int unsigned SS_LEAD    = 20,
  parameter int unsigned SS_HOLD    = 20,
  parameter int unsigned SS_GAP     = 20
) (
  input  logic                  sys_clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [FRAME_BITS-1:0] tx_data,
  output logic                  busy,
  output logic [FRAME_BITS-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  miso_in,
  output logic                  mosi_out,
  output logic                  sclk_out,
  output logic                  ss_out
);

  import spi_frame_pkg::*;

  localparam int unsigned CNT_MAX = max_of(max_of(CLK_DIV, SS_LEAD), max_of(SS_HOLD, SS_GAP));
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned BIT_W   = $clog2(FRAME_BITS + 1);

  state_t                  state, state_d;
  logic [CNT_W-1:0]        cnt, cnt_d;
  logic [BIT_W-1:0]        bit_cnt, bit_d;
  // Holds only the bits still to be sent; the bit on the wire lives in mosi_out.
  logic [FRAME_BITS-2:0]   tx_sr, tx_sr_d;
  logic [FRAME_BITS-1:0]   rx_sr, rx_sr_d;
  logic [FRAME_BITS-1:0]   rx_data_d;
  logic                    sclk_d, mosi_d, ss_d, busy_d, rx_valid_d;
  logic                    miso_s;

  bit_sync u_miso_sync (
    .clk   (sys_clk),
    .rst_n (rst_n),
    .d     (miso_in),
    .q     (miso_s)
  );

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      bit_cnt  <= '0;
      tx_sr    <= '0;
      rx_sr    <= '0;
      sclk_out <= 1'b0;
      mosi_out <= 1'b0;
      ss_out   <= 1'b0;
      busy     <= 1'b0;
      rx_valid <= 1'b0;
      rx_data  <= '0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      bit_cnt  <= bit_d;
      tx_sr    <= tx_sr_d;
      rx_sr    <= rx_sr_d;
      sclk_out <= sclk_d;
      mosi_out <= mosi_d;
      ss_out   <= ss_d;
      busy     <= busy_d;
      rx_valid <= rx_valid_d;
      rx_data  <= rx_data_d;
    end
  end

  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    bit_d      = bit_cnt;
    tx_sr_d    = tx_sr;
    rx_sr_d    = rx_sr;
    sclk_d     = sclk_out;
    mosi_d     = mosi_out;
    ss_d       = ss_out;
    busy_d     = busy;
    rx_valid_d = 1'b0;
    rx_data_d  = rx_data;

    unique case (state)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_LEAD;
          cnt_d   = CNT_W'(SS_LEAD - 1);
          bit_d   = BIT_W'(FRAME_BITS - 1);
          tx_sr_d = tx_data[FRAME_BITS-2:0];
          mosi_d  = tx_data[FRAME_BITS-1];
          sclk_d  = 1'b0;
          ss_d    = 1'b1;
          busy_d  = 1'b1;
        end
      end

      ST_LEAD: begin
        if (cnt == '0) begin
          state_d = ST_SHIFT;
          cnt_d   = CNT_W'(CLK_DIV - 1);
        end else begin
          cnt_d = cnt - CNT_W'(1);
        end
      end

      ST_SHIFT: begin
        if (cnt != '0) begin
          cnt_d = cnt - CNT_W'(1);
        end else if (!sclk_out) begin
          sclk_d = 1'b1;
          cnt_d  = CNT_W'(CLK_DIV - 1);
        end else begin
          // Last cycle of the high phase: capture MISO, then fall and advance.
          rx_sr_d = {rx_sr[FRAME_BITS-2:0], miso_s};
          sclk_d  = 1'b0;
          if (bit_cnt == '0) begin
            state_d = ST_TRAIL;
            mosi_d  = 1'b0;
            cnt_d   = CNT_W'(SS_HOLD - 1);
          end else begin
            bit_d   = bit_cnt - BIT_W'(1);
            mosi_d  = tx_sr[FRAME_BITS-2];
            tx_sr_d = {tx_sr[FRAME_BITS-3:0], 1'b0};
            cnt_d   = CNT_W'(CLK_DIV - 1);
          end
        end
      end

      ST_TRAIL: begin
        if (cnt == '0) begin
          state_d    = ST_GAP;
          ss_d       = 1'b0;
          rx_data_d  = rx_sr;
          rx_valid_d = 1'b1;
          cnt_d      = CNT_W'(SS_GAP - 1);
        end else begin
          cnt_d = cnt - CNT_W'(1);
        end
      end

      ST_GAP: begin
        if (cnt == '0) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt - CNT_W'(1);
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_spi_frame_master.sv
// Scoreboarded bench for spi_frame_master: default-parameter instance with a mode-0
// slave model, plus a minimum-timing instance with MISO looped back to MOSI.
`timescale 1ns/1ps
module tb_spi_frame_master;
  import spi_frame_pkg::*;

  localparam int unsigned FB     = 20;
  localparam int unsigned DIV    = 10;
  localparam int unsigned LEAD   = 20;
  localparam int unsigned HOLD   = 20;
  localparam int unsigned GAP    = 20;
  localparam int unsigned DIV6   = 3;
  localparam int unsigned SS_HI  = LEAD + 2 * DIV * FB + HOLD;  // 440
  localparam int unsigned SS_HI6 = 1 + 2 * DIV6 * FB + 1;       // 122

  logic          sys_clk = 1'b0;
  logic          rst_n   = 1'b0;
  logic          start   = 1'b0;
  logic [FB-1:0] tx_data = '0;
  logic          busy, rx_valid, mosi, sclk, ss;
  logic [FB-1:0] rx_data;
  logic          miso = 1'b0;

  logic          start6 = 1'b0;
  logic [FB-1:0] tx6    = '0;
  logic          busy6, rx_valid6, mosi6, sclk6, ss6, miso6;
  logic [FB-1:0] rx_data6;
  assign miso6 = mosi6;

  always #5 sys_clk = ~sys_clk;

  spi_frame_master u_dut (
    .sys_clk  (sys_clk),
    .rst_n    (rst_n),
    .start    (start),
    .tx_data  (tx_data),
    .busy     (busy),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .miso_in  (miso),
    .mosi_out (mosi),
    .sclk_out (sclk),
    .ss_out   (ss)
  );

  spi_frame_master #(
    .FRAME_BITS (FB),
    .CLK_DIV    (DIV6),
    .SS_LEAD    (1),
    .SS_HOLD    (1),
    .SS_GAP     (1)
  ) u_dut6 (
    .sys_clk  (sys_clk),
    .rst_n    (rst_n),
    .start    (start6),
    .tx_data  (tx6),
    .busy     (busy6),
    .rx_data  (rx_data6),
    .rx_valid (rx_valid6),
    .miso_in  (miso6),
    .mosi_out (mosi6),
    .sclk_out (sclk6),
    .ss_out   (ss6)
  );

  typedef struct packed {
    logic [FB-1:0] tx;
    logic [FB-1:0] rx;
  } frame_t;

  frame_t        exp_q[$];
  logic [FB-1:0] exp6_q[$];
  int            n_cmp = 0;
  int            n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name, input int limit);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: no event within %0d cycles", name, limit);
  endtask

  // Slave model + scoreboard monitor for the default instance.
  logic          prev_ss = 1'b0, prev_sclk = 1'b0;
  int            ss_hi_cnt = 0, ss_lo_cnt = 0, rises = 0, cyc = 0, last_rise = 0;
  int            period_err = 0, last_gap = 0, frames_started = 0, n_valid = 0;
  logic [FB-1:0] mosi_word = '0, last_mosi = '0, cur_miso = '0;
  frame_t        e;

  always @(negedge sys_clk) begin
    if (!rst_n) begin
      prev_ss = 1'b0; prev_sclk = 1'b0; rises = 0; ss_hi_cnt = 0; ss_lo_cnt = 0;
      period_err = 0; miso = 1'b0;
    end else begin
      cyc++;
      if (rx_valid) begin
        n_valid++;
        check("rx_valid_has_pending_frame", 32'(exp_q.size() > 0), 1);
        check("ss_low_at_rx_valid", 32'(ss), 0);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("rx_data", 32'(rx_data), 32'(e.rx));
          check("mosi_frame", 32'(mosi_word), 32'(e.tx));
          check("sclk_rise_count", rises, FB);
          check("ss_high_cycles", ss_hi_cnt, SS_HI);
          check("sclk_period_errors", period_err, 0);
        end
        last_mosi = mosi_word;
      end
      if (ss && !prev_ss) begin
        last_gap  = ss_lo_cnt;
        ss_lo_cnt = 0; ss_hi_cnt = 0; rises = 0; mosi_word = '0; period_err = 0;
        frames_started++;
        cur_miso = (exp_q.size() > 0) ? exp_q[0].rx : '0;
        miso     = cur_miso[FB-1];
      end
      if (ss) ss_hi_cnt++;
      else    ss_lo_cnt++;
      if (sclk && !prev_sclk) begin
        check("sclk_rise_inside_ss", 32'(ss), 1);
        if (rises > 0 && (cyc - last_rise) != int'(2 * DIV)) period_err++;
        last_rise = cyc;
        mosi_word = {mosi_word[FB-2:0], mosi};
        rises++;
      end
      // Mode-0 slave: next MISO bit goes out after each falling edge.
      if (!sclk && prev_sclk) miso = (rises < int'(FB)) ? cur_miso[FB-1-rises] : 1'b0;
      if (!ss) miso = 1'b0;
      prev_ss   = ss;
      prev_sclk = sclk;
    end
  end

  // Monitor for the minimum-timing loopback instance.
  logic prev_ss6 = 1'b0, prev_sclk6 = 1'b0;
  int   hi6 = 0, rises6 = 0, last_rise6 = 0, period_err6 = 0;
  logic [FB-1:0] e6;

  always @(negedge sys_clk) begin
    if (!rst_n) begin
      prev_ss6 = 1'b0; prev_sclk6 = 1'b0; hi6 = 0; rises6 = 0; period_err6 = 0;
    end else begin
      if (rx_valid6) begin
        check("c6_rx_valid_has_pending_frame", 32'(exp6_q.size() > 0), 1);
        if (exp6_q.size() > 0) begin
          e6 = exp6_q.pop_front();
          check("c6_rx_loopback", 32'(rx_data6), 32'(e6));
          check("c6_sclk_rise_count", rises6, FB);
          check("c6_ss_high_cycles", hi6, SS_HI6);
          check("c6_sclk_period_errors", period_err6, 0);
        end
      end
      if (ss6 && !prev_ss6) begin
        hi6 = 0; rises6 = 0; period_err6 = 0;
      end
      if (ss6) hi6++;
      if (sclk6 && !prev_sclk6) begin
        if (rises6 > 0 && (cyc - last_rise6) != int'(2 * DIV6)) period_err6++;
        last_rise6 = cyc;
        rises6++;
      end
      prev_ss6   = ss6;
      prev_sclk6 = sclk6;
    end
  end

  task automatic wait_busy_low(input string name, input int limit);
    int n = 0;
    while (busy !== 1'b0) begin
      @(negedge sys_clk);
      n++;
      if (n > limit) begin
        timeout(name, limit);
        return;
      end
    end
  endtask

  task automatic wait_busy6_low(input string name, input int limit);
    int n = 0;
    while (busy6 !== 1'b0) begin
      @(negedge sys_clk);
      n++;
      if (n > limit) begin
        timeout(name, limit);
        return;
      end
    end
  endtask

  task automatic wait_rises(input int target, input int limit);
    int n = 0;
    while (rises < target) begin
      @(negedge sys_clk);
      n++;
      if (n > limit) begin
        timeout("wait_sclk_rises", limit);
        return;
      end
    end
  endtask

  task automatic send(input logic [FB-1:0] tx, input logic [FB-1:0] mi);
    exp_q.push_back(frame_t'{tx: tx, rx: mi});
    start   = 1'b1;
    tx_data = tx;
    @(negedge sys_clk);
    start = 1'b0;
    check("busy_after_accept", 32'(busy), 1);
    wait_busy_low("frame_done", 2000);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int v0, fs;
    repeat (3) @(negedge sys_clk);
    check("reset_sclk", 32'(sclk), 0);
    check("reset_mosi", 32'(mosi), 0);
    check("reset_ss", 32'(ss), 0);
    check("reset_busy", 32'(busy), 0);
    check("reset_rx_valid", 32'(rx_valid), 0);
    check("reset_rx_data", 32'(rx_data), 0);
    check("reset_ss6", 32'(ss6), 0);
    rst_n = 1'b1;
    @(negedge sys_clk);

    // Read frame
    send(20'hC9A00, 20'h000A3);
    check("read_cmd_decode", 32'(last_mosi[FB-1 -: 3]), 32'(CMD_READ));
    check("read_valid_count", n_valid, 1);

    // Write frame with MISO idle
    send(20'hA376D, 20'h00000);
    check("write_cmd_decode", 32'(last_mosi[19:17]), 32'(CMD_WRITE));
    check("write_addr_decode", 32'(last_mosi[16:8]), 32'h037);
    check("write_data_decode", 32'(last_mosi[7:0]), 32'h6D);

    // Back-to-back with start held high
    v0 = n_valid;
    exp_q.push_back(frame_t'{tx: 20'hC9A00, rx: 20'h00000});
    exp_q.push_back(frame_t'{tx: 20'hD2000, rx: 20'h000B5});
    start   = 1'b1;
    tx_data = 20'hC9A00;
    @(negedge sys_clk);
    tx_data = 20'hD2000;
    wait_busy_low("b2b_first", 2000);
    @(negedge sys_clk);
    start = 1'b0;
    check("b2b_second_accept", 32'(busy), 1);
    @(negedge sys_clk);
    check("b2b_ss_gap_cycles", last_gap, GAP + 1);
    wait_busy_low("b2b_second", 2000);
    check("b2b_valid_pulses", n_valid - v0, 2);

    // Start while busy must be ignored
    fs = frames_started;
    exp_q.push_back(frame_t'{tx: 20'hA376D, rx: FB'($urandom)});
    start   = 1'b1;
    tx_data = 20'hA376D;
    @(negedge sys_clk);
    start = 1'b0;
    wait_rises(5, 1000);
    tx_data = 20'hFFFFF;
    start   = 1'b1;
    @(negedge sys_clk);
    start = 1'b0;
    wait_busy_low("ignored_start_frame", 2000);
    repeat (40) @(negedge sys_clk);
    check("ignored_start_frames", frames_started - fs, 1);
    check("ignored_start_idle", 32'(busy), 0);

    // Reset in the middle of a frame
    exp_q.push_back(frame_t'{tx: 20'hC9A00, rx: 20'h5A5A5});
    start   = 1'b1;
    tx_data = 20'hC9A00;
    @(negedge sys_clk);
    start = 1'b0;
    wait_rises(7, 1000);
    v0    = n_valid;
    rst_n = 1'b0;
    #1;
    check("abort_sclk", 32'(sclk), 0);
    check("abort_mosi", 32'(mosi), 0);
    check("abort_ss", 32'(ss), 0);
    check("abort_busy", 32'(busy), 0);
    check("abort_rx_data", 32'(rx_data), 0);
    exp_q.delete();
    repeat (5) @(negedge sys_clk);
    rst_n = 1'b1;
    repeat (3) @(negedge sys_clk);
    check("abort_no_rx_valid", n_valid - v0, 0);
    send(20'hC9A00, 20'h5A5A5);

    // Randomized frames
    repeat (12) begin
      repeat ($urandom_range(0, 15)) @(negedge sys_clk);
      send(FB'($urandom), FB'($urandom));
    end

    // Minimum-timing instance, MISO looped back
    for (int i = 0; i < 6; i++) begin
      logic [FB-1:0] t;
      t = (i == 0) ? 20'hC9A00 : FB'($urandom);
      exp6_q.push_back(t);
      start6 = 1'b1;
      tx6    = t;
      @(negedge sys_clk);
      start6 = 1'b0;
      tx6    = ~t;
      wait_busy6_low("c6_frame_done", 500);
      repeat ($urandom_range(0, 3)) @(negedge sys_clk);
    end

    repeat (5) @(negedge sys_clk);
    check("all_frames_retired", exp_q.size(), 0);
    check("c6_all_frames_retired", exp6_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
